// File: rtl/program_loader.sv
// Byte-stream program loader: packs a length-prefixed frame into words
// and writes them to instruction memory from 0. Option: CHECKSUM_EN.
module program_loader #(
  parameter int AWIDTH = 15,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    FIN,
`ifdef CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t              state;
  logic [AWIDTH-1:0]   cnt;
  logic [15:0]         left;
  logic [7:0]          len_lo;
  logic [1:0]          bidx;
  logic [DWIDTH-1:0]   word;
  logic                xfer;
`ifdef CHECKSUM_EN
  logic [7:0]          xsum;
`endif

  assign xfer    = in_valid & in_ready;
  assign cpu_rst = rst | busy;

`ifndef CHECKSUM_EN
  assign err = 1'b0;
`endif

  // Frame FSM with registered outputs; in_ready tracks the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      left     <= '0;
      len_lo   <= '0;
      bidx     <= '0;
      word     <= '0;
      in_ready <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef CHECKSUM_EN
      err      <= 1'b0;
      xsum     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LEN_LO;
            in_ready <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            bidx     <= '0;
`ifdef CHECKSUM_EN
            err      <= 1'b0;
            xsum     <= '0;
`endif
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_lo <= in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            left <= {in_data, len_lo};
            if ({in_data, len_lo} == 16'd0) begin
              state    <= FIN;
              in_ready <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            word[{bidx, 3'b000} +: 8] <= in_data;
            bidx <= bidx + 2'd1;
`ifdef CHECKSUM_EN
            xsum <= xsum ^ in_data;
`endif
            if (bidx == 2'd3) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              mem_wr   <= 1'b1;
              mem_addr <= cnt;
              mem_data <= {in_data, word[DWIDTH-9:0]};
            end
          end
        end
        WRITE: begin
          mem_wr <= 1'b0;
          cnt    <= cnt + AWIDTH'(1);
          left   <= left - 16'd1;
          if (left == 16'd1) begin
            state <= FIN;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end
        FIN: begin
`ifdef CHECKSUM_EN
          state    <= CHK;
          in_ready <= 1'b1;
`else
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
`endif
        end
`ifdef CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            err      <= (in_data != xsum);
            state    <= DONE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          mem_wr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes queued by the
// stimulus, popped by a monitor on each mem_wr pulse.
module tb_program_loader;

  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_rst;

  int errors = 0;
  int checks = 0;

  logic [AW+DW-1:0] exp_q[$];

  program_loader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_rst  (cpu_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && mem_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 mem_addr, mem_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          errors++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   mem_addr, mem_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
    end
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", {63'd0, done}, 64'd1);
  endtask

  task automatic send_frame2(input bit gap);
    logic [7:0] f[10];
    f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
          8'hEF, 8'hBE, 8'hAD, 8'hDE};
    expect_wr(15'd0, 32'h12345678);
    expect_wr(15'd1, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) send(f[i], gap);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
    chk("idle_cpu_rst", {63'd0, cpu_rst}, 64'd0);

    // Back-to-back frame.
    pulse_start();
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    send(8'h02, 0);
    send(8'h00, 0);
    expect_wr(15'd0, 32'h12345678);
    expect_wr(15'd1, 32'hDEADBEEF);
    send(8'h78, 0);
    send(8'h56, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    chk("wr_latency", {63'd0, mem_wr}, 64'd1);
    chk("write_in_ready", {63'd0, in_ready}, 64'd0);
    send(8'hEF, 0);
    send(8'hBE, 0);
    send(8'hAD, 0);
    send(8'hDE, 0);
    in_valid = 1'b0;
    wait_done();
    chk("t2_busy", {63'd0, busy}, 64'd0);
    chk("t2_cpu_rst", {63'd0, cpu_rst}, 64'd0);
    chk("t2_err", {63'd0, err}, 64'd0);
    chk("t2_addr_hold", {49'd0, mem_addr}, 64'd1);
    chk("t2_data_hold", {32'd0, mem_data}, 64'h00000000DEADBEEF);

    // Toggling in_valid.
    pulse_start();
    send_frame2(1);
    wait_done();
    chk("t3_busy", {63'd0, busy}, 64'd0);

    // Empty frame.
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    in_valid = 1'b0;
    wait_done();
    chk("t4_busy", {63'd0, busy}, 64'd0);

    // Async reset mid-load after one word is written.
    pulse_start();
    send(8'h02, 0);
    send(8'h00, 0);
    expect_wr(15'd0, 32'h12345678);
    send(8'h78, 0);
    send(8'h56, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'hEF, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("arst_mem_wr", {63'd0, mem_wr}, 64'd0);
    chk("arst_addr", {49'd0, mem_addr}, 64'd0);
    chk("arst_data", {32'd0, mem_data}, 64'd0);
    chk("arst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    @(negedge clk);
    chk("arst_cpu_rst_hold", {63'd0, cpu_rst}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // start mid-DATA ignored, rst aborts without a write.
    pulse_start();
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    in_valid = 1'b0;
    pulse_start();
    chk("t5_busy", {63'd0, busy}, 64'd1);
    chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_done", {63'd0, done}, 64'd0);
    pulse_start();
    send_frame2(0);
    wait_done();

    // Checksum frame.
    pulse_start();
    expect_wr(15'd0, 32'h44332211);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
`ifdef CHECKSUM_EN
    send(8'h44, 0);
    in_valid = 1'b0;
    wait_done();
    chk("chk_ok_err", {63'd0, err}, 64'd0);
    pulse_start();
    expect_wr(15'd0, 32'h44332211);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    send(8'h45, 0);
    in_valid = 1'b0;
    wait_done();
    chk("chk_bad_err", {63'd0, err}, 64'd1);
`else
    in_valid = 1'b0;
    wait_done();
    in_valid = 1'b1;
    in_data = 8'h45;
    repeat (3) @(negedge clk);
    chk("nochk_in_ready", {63'd0, in_ready}, 64'd0);
    chk("nochk_err", {63'd0, err}, 64'd0);
    chk("nochk_done", {63'd0, done}, 64'd1);
    in_valid = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
